// File: rtl/kernel_dds_table_reader_if.sv
// Signal bundle between the DDS table reader, its control inputs, the kernel RAM read port and the
// DAC sample stream. The reader itself uses the slave view.
interface kernel_dds_table_reader_if #(
  parameter int SAMPLE_W = 16
) ();
  logic                enable;
  logic                sync_clr;
  logic [31:0]         tuning_word;
  logic [31:0]         phase_offset;
  logic [13:0]         ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic [3:0]          ram_byteenable;
  logic                ram_clken;
  logic [31:0]         ram_readdata;
  logic [SAMPLE_W-1:0] smp_data;
  logic                smp_valid;
  logic                smp_ready;

  modport slave (
    input  enable, sync_clr, tuning_word, phase_offset, ram_readdata, smp_ready,
    output ram_address, ram_chipselect, ram_write, ram_byteenable, ram_clken, smp_data, smp_valid
  );

  modport master (
    output enable, sync_clr, tuning_word, phase_offset, ram_readdata, smp_ready,
    input  ram_address, ram_chipselect, ram_write, ram_byteenable, ram_clken, smp_data, smp_valid
  );
endinterface

// File: rtl/kernel_dds_table_reader.sv
// DDS read stage: phase accumulator fetching waveform-table words from kernel RAM into a 2-entry
// skid buffer feeding a valid/ready sample stream. Optional phase dither: KERNEL_DDS_PHASE_DITHER_EN.
//
// state    | meaning
// ST_IDLE  | no fetches, buffer empty, waiting for enable
// ST_RUN   | fetching one table word per step while buffer + in-flight leave room
// ST_DRAIN | enable dropped; no fetch, the word still landing is dropped, then back to idle
module kernel_dds_table_reader #(
  parameter int TABLE_AW   = 10,
  parameter int TABLE_BASE = 0,
  parameter int SAMPLE_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  kernel_dds_table_reader_if.slave bus_io
);

  localparam int IDX_LSB = 32 - TABLE_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e              state_q;
  logic [31:0]         phase_q;
  logic                land_q;
  logic [1:0]          cnt_q;
  logic [SAMPLE_W-1:0] buf0_q;
  logic [SAMPLE_W-1:0] buf1_q;

  logic [TABLE_AW-1:0] idx;
  logic [SAMPLE_W-1:0] rd_smp;
  logic                pop;
  logic                push;
  logic                issue;
  logic [1:0]          occ_after;
  logic [2:0]          committed;

`ifdef KERNEL_DDS_PHASE_DITHER_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [31:0] dith;

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  // LFSR sits right under the index LSB; only a carry can reach the index
  assign dith   = {lfsr_q, 16'h0000} >> TABLE_AW;
  assign idx    = TABLE_AW'((phase_q + dith) >> IDX_LSB);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || bus_io.sync_clr) begin
      lfsr_q <= 16'hACE1;
    end else if (issue) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign idx = TABLE_AW'(phase_q >> IDX_LSB);
`endif

  assign rd_smp    = bus_io.ram_readdata[SAMPLE_W-1:0];
  assign pop       = (cnt_q != 2'd0) && bus_io.smp_ready;
  assign push      = land_q && (state_q == ST_RUN);
  assign occ_after = cnt_q - {1'b0, pop};
  assign committed = {1'b0, occ_after} + {2'b00, land_q};
  assign issue     = reset_n_i && (state_q == ST_RUN) && !bus_io.sync_clr && (committed < 3'd2);

  assign bus_io.ram_chipselect = issue;
  assign bus_io.ram_address    = issue ? (14'(TABLE_BASE) + 14'(idx)) : 14'(TABLE_BASE);
  assign bus_io.ram_write      = 1'b0;
  assign bus_io.ram_byteenable = 4'hF;
  assign bus_io.ram_clken      = 1'b1;
  assign bus_io.smp_data       = buf0_q;
  assign bus_io.smp_valid      = (cnt_q != 2'd0);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      phase_q <= bus_io.phase_offset;
      land_q  <= 1'b0;
      cnt_q   <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      land_q <= issue;
      if (issue) begin
        phase_q <= phase_q + bus_io.tuning_word;
      end

      case (cnt_q)
        2'd0: begin
          if (push) begin
            buf0_q <= rd_smp;
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            buf0_q <= rd_smp;
          end else if (pop) begin
            cnt_q <= 2'd0;
          end else if (push) begin
            buf1_q <= rd_smp;
            cnt_q  <= 2'd2;
          end
        end
        default: begin
          // full: issue is held off, so a push here always comes with a pop
          if (pop) begin
            buf0_q <= buf1_q;
            if (push) begin
              buf1_q <= rd_smp;
            end else begin
              cnt_q <= 2'd1;
            end
          end
        end
      endcase

      case (state_q)
        ST_IDLE: begin
          if (bus_io.enable) begin
            state_q <= ST_RUN;
            phase_q <= bus_io.phase_offset;
          end
        end
        ST_RUN: begin
          if (!bus_io.enable && !bus_io.sync_clr) begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          // DRAIN never issues, so the single outstanding word lands (and is dropped) this cycle
          state_q <= ST_IDLE;
          cnt_q   <= 2'd0;
        end
      endcase

      if (bus_io.sync_clr) begin
        phase_q <= bus_io.phase_offset;
        cnt_q   <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_kernel_dds_table_reader.sv
// Scoreboard bench for kernel_dds_table_reader: directed streams push expected samples, a monitor
// pops and compares on every accepted handshake.
module tb_kernel_dds_table_reader;
  localparam int TABLE_AW   = 10;
  localparam int TABLE_BASE = 0;
  localparam int SAMPLE_W   = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kernel_dds_table_reader_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  kernel_dds_table_reader #(
    .TABLE_AW  (TABLE_AW),
    .TABLE_BASE(TABLE_BASE),
    .SAMPLE_W  (SAMPLE_W)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus_io   (bus)
  );

  logic [31:0] mem [0:10239];
  initial for (int i = 0; i < 10240; i++) mem[i] = 32'hDEAD_0000 | 32'(i % 1024);

  always @(posedge clk) begin
    if (bus.ram_chipselect && bus.ram_address < 14'd10240) bus.ram_readdata <= mem[bus.ram_address];
  end

  int n_err = 0;
  int n_chk = 0;
  int n_acc = 0;
  int n_cs  = 0;
  int exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_smp(input string name, input int act, input int exp);
    bit ok;
`ifdef KERNEL_DDS_PHASE_DITHER_EN
    ok = (act == exp) || (act == ((exp + 1) % 1024));
`else
    ok = (act == exp);
`endif
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // monitor: samples 1 time unit after the falling edge, acceptance happens at the next rising edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (bus.ram_chipselect) n_cs++;
        if (bus.smp_valid && bus.smp_ready) begin
          n_acc++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_sample: got %0d want none", bus.smp_data);
          end else begin
            check_smp("sample", int'(bus.smp_data), exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_stream(input logic [31:0] tw, input logic [31:0] off);
    int lat;
    @(negedge clk);
    bus.tuning_word  = tw;
    bus.phase_offset = off;
    bus.enable       = 1'b1;
    bus.smp_ready    = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #2;
      if (bus.smp_valid) begin
        lat = k;
        break;
      end
    end
    check("first_valid_latency", lat, 3);
  endtask

  task automatic wait_acc(input int target, input int budget, output int cycles);
    cycles = 0;
    while (n_acc < target && cycles < budget) begin
      @(negedge clk);
      #2;
      cycles++;
    end
    if (n_acc < target) check("accept_timeout", n_acc, target);
  endtask

  task automatic stop_stream();
    @(negedge clk);
    bus.smp_ready = 1'b0;
    repeat (4) @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("idle_valid_low", bus.smp_valid, 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int a0;
    int c0;
    int cyc;
    bus.enable       = 1'b1;
    bus.sync_clr     = 1'b0;
    bus.tuning_word  = 32'h0;
    bus.phase_offset = 32'h0;
    bus.smp_ready    = 1'b0;

    // T1: reset held with enable high
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("rst_valid", bus.smp_valid, 0);
      check("rst_cs", bus.ram_chipselect, 0);
      check("rst_addr", bus.ram_address, TABLE_BASE);
      check("rst_data", bus.smp_data, 0);
      check("rst_write", bus.ram_write, 0);
      check("rst_be", bus.ram_byteenable, 4'hF);
      check("rst_clken", bus.ram_clken, 1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    check("t1_full_cs", bus.ram_chipselect, 0);
    check("t1_full_valid", bus.smp_valid, 1);
    check_smp("t1_head", int'(bus.smp_data), 0);
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("t1_idle_valid", bus.smp_valid, 0);

    // T2: full table sweep plus wrap, back to back
    for (int i = 0; i <= 1024; i++) exp_q.push_back(i % 1024);
    a0 = n_acc;
    start_stream(32'h0040_0000, 32'h0);
    wait_acc(a0 + 1025, 1100, cyc);
    check("t2_gapless_cycles", cyc, 1024);
    stop_stream();

    // T3: odd indices with 32-bit phase wrap
    exp_q = '{1023, 1, 3, 5, 7, 9};
    a0 = n_acc;
    start_stream(32'h0080_0000, 32'hFFC0_0000);
    wait_acc(a0 + 6, 50, cyc);
    stop_stream();

    // T4: backpressure for 10 cycles mid-stream
    for (int i = 0; i < 40; i++) exp_q.push_back(i);
    a0 = n_acc;
    c0 = n_cs;
    start_stream(32'h0040_0000, 32'h0);
    wait_acc(a0 + 20, 50, cyc);
    @(negedge clk);
    bus.smp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #2;
      check("t4_stall_cs", bus.ram_chipselect, 0);
      check("t4_stall_valid", bus.smp_valid, 1);
      check_smp("t4_stall_data", int'(bus.smp_data), n_acc - a0);
      @(negedge clk);
    end
    check("t4_fetched_two_ahead", n_cs - c0, (n_acc - a0) + 2);
    bus.smp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #2;
      check("t4_resume_valid", bus.smp_valid, 1);
      @(negedge clk);
    end
    wait_acc(a0 + 40, 50, cyc);
    stop_stream();

    // T5: enable drop with one word in flight, then restart at a new offset
    for (int i = 0; i < 7; i++) exp_q.push_back(i);
    a0 = n_acc;
    start_stream(32'h0040_0000, 32'h0);
    wait_acc(a0 + 5, 50, cyc);
    @(negedge clk);
    bus.enable = 1'b0;
    #2;
    check("t5_last_run_valid", bus.smp_valid, 1);
    @(negedge clk);
    #2;
    check("t5_drain_valid", bus.smp_valid, 1);
    check("t5_drain_cs", bus.ram_chipselect, 0);
    @(negedge clk);
    #2;
    check("t5_idle_valid", bus.smp_valid, 0);
    check("t5_accepted", n_acc - a0, 7);
    check("t5_queue", exp_q.size(), 0);
    exp_q = '{4, 5, 6};
    a0 = n_acc;
    start_stream(32'h0040_0000, 32'h0100_0000);
    wait_acc(a0 + 3, 50, cyc);
    stop_stream();

    // T6: sync_clr during a running stream
    exp_q = '{8, 9, 10, 11, 12, 8, 9, 10, 11};
    a0 = n_acc;
    start_stream(32'h0040_0000, 32'h0200_0000);
    wait_acc(a0 + 4, 50, cyc);
    @(negedge clk);
    bus.sync_clr = 1'b1;
    @(negedge clk);
    bus.sync_clr = 1'b0;
    #2;
    check("t6_clr_valid_c1", bus.smp_valid, 0);
    @(negedge clk);
    #2;
    check("t6_clr_valid_c2", bus.smp_valid, 0);
    @(negedge clk);
    #2;
    check("t6_restart_valid", bus.smp_valid, 1);
    check_smp("t6_restart_data", int'(bus.smp_data), 8);
    wait_acc(a0 + 9, 50, cyc);
    stop_stream();

    // T7: half-step tuning, each index repeats twice
    for (int i = 0; i < 16; i++) exp_q.push_back(i / 2);
    a0 = n_acc;
    start_stream(32'h0020_0000, 32'h0);
    wait_acc(a0 + 16, 60, cyc);
    stop_stream();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
